audio_ns_i2s_bridge: RTL and testbench

Serial-side partner of fix_audio_ns. Deserialises the left-channel word from an external I2S slave link (bclk/lrclk/sdin) and presents it on rx_data. Acts as initiator of the core's toggle req/ack handshake. Latches the core's tx_data on each ack toggle and serialises it back out on sdout in both I2S slots (mono duplicate).

---
 rtl/audio_ns_pkg.sv | 17 +
 rtl/audio_ns_sync_edge.sv | 34 +++
 rtl/audio_ns_i2s_bridge.sv | 167 ++++++++++++++++
 tb/tb_audio_ns_i2s_bridge.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/audio_ns_pkg.sv
// Shared types and constants for the audio_ns I2S bridge.
package audio_ns_pkg;

    localparam int unsigned SampleWidth   = 16;
    localparam int unsigned SyncDepth     = 2;
    // Worst-case clk cycles from the last-bit bclk rise to the req toggle.
    localparam int unsigned MaxReqLatency = 4;

    typedef logic signed [SampleWidth-1:0] sample_t;

    typedef enum logic [1:0] {
        StIdle,
        StAlign,
        StRun
    } state_e;

endpackage

// File: rtl/audio_ns_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level, with rise/fall pulses
// derived from the synchronised level.
module audio_ns_sync_edge
    import audio_ns_pkg::*;
#(
    parameter int unsigned Depth = SyncDepth
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [Depth-1:0] sync_q;
    logic             prev_q;

    // Shift the async input through the synchroniser, keep one more stage for edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[Depth-2:0], d_i};
            prev_q <= sync_q[Depth-1];
        end
    end

    assign q_o    = sync_q[Depth-1];
    assign rise_o = q_o & ~prev_q;
    assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/audio_ns_i2s_bridge.sv
// I2S slave bridge: deserialises the left word towards the core over a toggle
// req/ack handshake and serialises the core's answer onto both output slots.
module audio_ns_i2s_bridge
    import audio_ns_pkg::*;
#(
    parameter int unsigned FIXWID = 16,
    parameter int unsigned SLOT   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              bclk,
    input  logic              lrclk,
    input  logic              sdin,
    output logic              sdout,
    output logic              req,
    input  logic              ack,
    output logic [FIXWID-1:0] rx_data,
    input  logic [FIXWID-1:0] tx_data,
    output logic              overflow
);

    localparam int unsigned RxCntW = $clog2(FIXWID + 1);
    localparam int unsigned TxCntW = $clog2(SLOT + 1);
    localparam logic [RxCntW-1:0] RxLast = RxCntW'(FIXWID - 1);
    localparam logic [RxCntW-1:0] RxFull = RxCntW'(FIXWID);
    localparam logic [TxCntW-1:0] TxData = TxCntW'(FIXWID);
    localparam logic [TxCntW-1:0] TxFull = TxCntW'(SLOT);

    logic bclk_s, bclk_rise, bclk_fall;
    logic lr_s, lr_rise, lr_fall;
    logic sdin_s, sdin_rise, sdin_fall;

    audio_ns_sync_edge u_bclk_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (bclk),
        .q_o    (bclk_s),
        .rise_o (bclk_rise),
        .fall_o (bclk_fall)
    );

    audio_ns_sync_edge u_lrclk_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (lrclk),
        .q_o    (lr_s),
        .rise_o (lr_rise),
        .fall_o (lr_fall)
    );

    audio_ns_sync_edge u_sdin_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (sdin),
        .q_o    (sdin_s),
        .rise_o (sdin_rise),
        .fall_o (sdin_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{bclk_s, sdin_rise, sdin_fall};

    state_e            state_q;
    logic [RxCntW-1:0] rx_cnt_q;
    logic [TxCntW-1:0] tx_cnt_q;
    logic              skip_q;
    logic [FIXWID-1:0] rx_shift_q, tx_shift_q, tx_hold_q, rx_data_q;
    logic              ack_q, pending_q, req_q, overflow_q, sdout_q;

    logic              lr_edge, ack_evt, pending_eff;
    logic [FIXWID-1:0] rx_shift_nxt;

    // An ack toggle in the same cycle as a word completion frees the slot first.
    always_comb begin
        lr_edge      = lr_rise | lr_fall;
        ack_evt      = ack != ack_q;
        pending_eff  = pending_q & ~ack_evt;
        rx_shift_nxt = {rx_shift_q[FIXWID-2:0], sdin_s};
    end

    // Bridge FSM with handshake, receive shifter and transmit shifter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            rx_cnt_q   <= '0;
            tx_cnt_q   <= '0;
            skip_q     <= 1'b0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            tx_hold_q  <= '0;
            rx_data_q  <= '0;
            ack_q      <= 1'b0;
            pending_q  <= 1'b0;
            req_q      <= 1'b0;
            overflow_q <= 1'b0;
            sdout_q    <= 1'b0;
        end else begin
            pending_q <= pending_eff;
            if (ack_evt) begin
                tx_hold_q <= tx_data;
                ack_q     <= ack;
            end

            if (!enable) begin
                // Counters restart on the next slot, so a partial word is simply lost.
                state_q    <= StIdle;
                rx_cnt_q   <= '0;
                tx_cnt_q   <= '0;
                skip_q     <= 1'b0;
                overflow_q <= 1'b0;
                sdout_q    <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: state_q <= StAlign;
                    StAlign, StRun: begin
                        if (lr_edge) begin
                            state_q    <= StRun;
                            rx_cnt_q   <= '0;
                            skip_q     <= 1'b1;
                            tx_shift_q <= tx_hold_q;
                            tx_cnt_q   <= '0;
                            sdout_q    <= 1'b0;
                        end else if (state_q == StRun) begin
                            if (bclk_rise) begin
                                if (skip_q) begin
                                    skip_q <= 1'b0;
                                end else if (rx_cnt_q < RxFull) begin
                                    rx_shift_q <= rx_shift_nxt;
                                    rx_cnt_q   <= rx_cnt_q + RxCntW'(1);
                                    // Only the left slot (lrclk low) reaches the core.
                                    if (rx_cnt_q == RxLast && !lr_s) begin
                                        if (!pending_eff) begin
                                            rx_data_q <= rx_shift_nxt;
                                            req_q     <= ~req_q;
                                            pending_q <= 1'b1;
                                        end else begin
                                            overflow_q <= 1'b1;
                                        end
                                    end
                                end
                            end
                            if (bclk_fall) begin
                                if (tx_cnt_q < TxData) begin
                                    sdout_q    <= tx_shift_q[FIXWID-1];
                                    tx_shift_q <= {tx_shift_q[FIXWID-2:0], 1'b0};
                                end else begin
                                    sdout_q <= 1'b0;
                                end
                                if (tx_cnt_q < TxFull) begin
                                    tx_cnt_q <= tx_cnt_q + TxCntW'(1);
                                end
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign sdout    = sdout_q;
    assign req      = req_q;
    assign rx_data  = rx_data_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_audio_ns_i2s_bridge.sv
// Scoreboard bench: an I2S master/core model drives the bridge and predicts
// forwarded words, overflow and sdout slot contents.
module tb_audio_ns_i2s_bridge;
    import audio_ns_pkg::*;

    logic        clk = 1'b0, rst = 1'b1, enable = 1'b0;
    logic        bclk = 1'b0, lrclk = 1'b0, sdin = 1'b0, ack = 1'b0;
    logic        sdout, req, overflow;
    logic [15:0] rx_data, tx_data = 16'h0;

    int checks = 0, errors = 0, cyc = 0;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    // Reference model of the bridge as seen from the outside.
    bit          m_pending = 0, m_ovf = 0, m_run = 0, m_align = 0;
    logic [15:0] m_hold = 16'h0;

    audio_ns_i2s_bridge #(.FIXWID(16), .SLOT(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .bclk     (bclk),
        .lrclk    (lrclk),
        .sdin     (sdin),
        .sdout    (sdout),
        .req      (req),
        .ack      (ack),
        .rx_data  (rx_data),
        .tx_data  (tx_data),
        .overflow (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] rnd16();
        return 16'($urandom);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Monitor: every req toggle must match the oldest predicted word, within latency.
    initial begin : monitor
        logic req_prev;
        exp_t e;
        req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                req_prev = 1'b0;
            end else if (req !== req_prev) begin
                req_prev = req;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_req: got toggle with rx_data %h want no toggle", rx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_data", {16'h0, rx_data}, {16'h0, e.data});
                    checks++;
                    if (cyc - e.cyc > int'(MaxReqLatency)) begin
                        errors++;
                        $display("FAIL req_latency: got %0d clk want <= %0d", cyc - e.cyc,
                                 MaxReqLatency);
                    end
                end
            end
        end
    end

    // One I2S slot of 32 bclk periods, 8 clk each; events hook in at fixed bit positions.
    // ack_mode: 0 none, 1 ack at bit 24, 2 ack on the word-completion clk.
    // en_ev: 1 drop enable, 2 raise enable. rst_ev: 1 assert reset, 2 release reset.
    task automatic do_slot(input bit ch, input logic [15:0] w, input int ack_mode,
                           input logic [15:0] txv, input int en_ev, input int rst_ev);
        logic [31:0] got, want;
        logic [15:0] tx_snap;
        bit          dirty, simul;
        dirty   = 0;
        got     = '0;
        tx_snap = 16'h0;
        for (int j = 0; j < 32; j++) begin
            @(negedge clk);
            bclk = 1'b0;
            if (j == 0) begin
                lrclk = ch;
                if (!rst && enable && (m_run || m_align)) begin
                    m_run   = 1;
                    m_align = 0;
                end
                tx_snap = m_run ? m_hold : 16'h0;
            end
            sdin = (j >= 1 && j <= 16) ? w[16-j] : 1'b0;
            if (j == 8 && en_ev == 1) begin
                enable = 1'b0;
                m_run = 0; m_align = 0; m_ovf = 0; dirty = 1;
            end
            if (j == 8 && en_ev == 2) begin
                enable  = 1'b1;
                m_align = !rst;
                dirty   = 1;
            end
            if (j == 10 && rst_ev == 1) begin
                #2 rst = 1'b1;
                ack = 1'b0;
                #1;
                check("rst_req", {31'h0, req}, 32'h0);
                check("rst_sdout", {31'h0, sdout}, 32'h0);
                check("rst_rx_data", {16'h0, rx_data}, 32'h0);
                check("rst_overflow", {31'h0, overflow}, 32'h0);
                m_pending = 0; m_ovf = 0; m_hold = 16'h0; m_run = 0; m_align = 0;
                dirty = 1;
            end
            if (j == 10 && rst_ev == 2) begin
                rst     = 1'b0;
                m_align = enable;
                dirty   = 1;
            end
            repeat (3) @(negedge clk);
            @(negedge clk);
            got[31-j] = sdout;
            bclk  = 1'b1;
            simul = 0;
            if (ch == 0 && j == 16) begin
                if (ack_mode == 2 && m_pending) begin
                    simul     = 1;
                    tx_data   = txv;
                    m_hold    = txv;
                    m_pending = 0;
                end
                if (m_run) begin
                    if (!m_pending) begin
                        exp_q.push_back('{w, cyc});
                        m_pending = 1;
                    end else begin
                        m_ovf = 1;
                    end
                end
            end
            if (ch == 0 && j == 24 && ack_mode == 1 && m_pending) begin
                tx_data   = txv;
                ack       = ~ack;
                m_hold    = txv;
                m_pending = 0;
            end
            @(negedge clk);
            @(negedge clk);
            // Lands on the same clk edge that completes the word.
            if (simul) ack = ~ack;
            @(negedge clk);
        end
        want = {1'b0, tx_snap, 15'h0};
        if (!dirty) check(ch ? "sdout_right" : "sdout_left", got, want);
    endtask

    task automatic do_frame(input logic [15:0] l, input logic [15:0] r, input int ack_mode,
                            input logic [15:0] txv, input int en_l, input int en_r,
                            input int rst_l, input int rst_r);
        do_slot(1'b0, l, ack_mode, txv, en_l, rst_l);
        do_slot(1'b1, r, 0, txv, en_r, rst_r);
        check("overflow", {31'h0, overflow}, {31'h0, m_ovf});
        if (rst) check("req_in_reset", {31'h0, req}, 32'h0);
    endtask

    initial begin
        repeat (5) @(negedge clk);
        rst = 1'b0;
        // Warm-up right slot; enable comes up mid-slot so the next left edge starts RUN.
        do_slot(1'b1, 16'h0, 0, 16'h0, 2, 0);

        // Fixed pattern and known tx word, then random traffic.
        do_frame(16'h1234, 16'hABCD, 1, 16'h8001, 0, 0, 0, 0);
        do_frame(16'h1234, 16'hABCD, 1, rnd16(), 0, 0, 0, 0);
        repeat (3) do_frame(rnd16(), rnd16(), 1, rnd16(), 0, 0, 0, 0);

        // Withheld ack, then ack on the exact completion clk.
        do_frame(rnd16(), rnd16(), 0, 16'h0, 0, 0, 0, 0);
        do_frame(rnd16(), rnd16(), 2, rnd16(), 0, 0, 0, 0);
        do_frame(rnd16(), rnd16(), 1, rnd16(), 0, 0, 0, 0);

        // Two frames without ack: second word overflows; ack afterwards recovers.
        do_frame(rnd16(), rnd16(), 0, 16'h0, 0, 0, 0, 0);
        do_frame(16'h5555, rnd16(), 0, 16'h0, 0, 0, 0, 0);
        do_frame(rnd16(), rnd16(), 1, rnd16(), 0, 0, 0, 0);
        do_frame(rnd16(), rnd16(), 1, rnd16(), 0, 0, 0, 0);

        // Disable mid left word, re-enable mid right slot.
        do_frame(rnd16(), rnd16(), 1, rnd16(), 1, 2, 0, 0);
        do_frame(rnd16(), rnd16(), 1, rnd16(), 0, 0, 0, 0);
        do_frame(rnd16(), rnd16(), 1, rnd16(), 0, 0, 0, 0);

        // Reset mid left word, held for two frames, released mid right slot.
        do_frame(rnd16(), rnd16(), 1, rnd16(), 0, 0, 1, 0);
        do_frame(rnd16(), rnd16(), 1, rnd16(), 0, 0, 0, 0);
        do_frame(rnd16(), rnd16(), 1, rnd16(), 0, 0, 0, 2);
        repeat (3) do_frame(rnd16(), rnd16(), 1, rnd16(), 0, 0, 0, 0);

        repeat (10) @(negedge clk);
        check("words_outstanding", exp_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
